// File: rtl/saes_pkg.sv
// Shared S-AES definitions for the key-schedule controller.
// Contents: key/byte/nibble widths, round constants, controller state
// encoding, and the 4-bit S-box substitution used by the g-function.
package saes_pkg;

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;

  localparam logic [BYTE_W-1:0] RCON1 = 8'h80;
  localparam logic [BYTE_W-1:0] RCON2 = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXP1  = 2'b01,
    ST_EXP2  = 2'b10,
    ST_READY = 2'b11
  } ksched_state_e;

  // S-AES nibble S-box
  function automatic logic [NIB_W-1:0] sub_nib(input logic [NIB_W-1:0] n);
    logic [NIB_W-1:0] s;
    case (n)
      4'h0: s = 4'h9;
      4'h1: s = 4'h4;
      4'h2: s = 4'hA;
      4'h3: s = 4'hB;
      4'h4: s = 4'hD;
      4'h5: s = 4'h1;
      4'h6: s = 4'h8;
      4'h7: s = 4'h5;
      4'h8: s = 4'h6;
      4'h9: s = 4'h2;
      4'hA: s = 4'h0;
      4'hB: s = 4'h3;
      4'hC: s = 4'hC;
      4'hD: s = 4'hE;
      4'hE: s = 4'hF;
      default: s = 4'h7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/saes_gfun.sv
// S-AES key-expansion g-function (combinational).
// Ports:
//   w     in  8  word to transform
//   rcon  in  8  round constant
//   gw_c  out 8  SubNib(RotNib(w)) ^ rcon
module saes_gfun
  import saes_pkg::*;
(
  input  logic [BYTE_W-1:0] w,
  input  logic [BYTE_W-1:0] rcon,
  output logic [BYTE_W-1:0] gw_c
);

  // Nibble rotation is folded into the output ordering
  assign gw_c = {sub_nib(w[3:0]), sub_nib(w[7:4])} ^ rcon;

endmodule

// File: rtl/saes_key_sched_ctrl.sv
// Sequential S-AES key-schedule controller. Accepts a 16-bit key over
// valid/ready and expands it into three round keys, one per cycle, through a
// single shared g-function. Rekeying is deferred while the core holds key_lock.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   key_in_valid  source offers key_in
//   key_in        cipher key {w0,w1}
//   key_in_ready  accept strobe (combinational)
//   key_lock      core is using the keys; blocks rekey when LOCK_EN=1
//   keys_valid    key0/key1/key2 complete and stable
//   key0..key2    round keys
//   busy          expansion in progress
//   exp_count     completed expansions, wraps modulo 2**CNT_W
module saes_key_sched_ctrl
  import saes_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter bit          LOCK_EN = 1'b1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in_valid,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_in_ready,
  input  logic             key_lock,
  output logic             keys_valid,
  output logic [KEY_W-1:0] key0,
  output logic [KEY_W-1:0] key1,
  output logic [KEY_W-1:0] key2,
  output logic             busy,
  output logic [CNT_W-1:0] exp_count
);

  ksched_state_e     state;
  logic              accept_c;
  logic [BYTE_W-1:0] g_in_c;
  logic [BYTE_W-1:0] g_rcon_c;
  logic [BYTE_W-1:0] g_out_c;
  logic [BYTE_W-1:0] w_hi_c;
  logic [BYTE_W-1:0] new_hi_c;
  logic [BYTE_W-1:0] new_lo_c;

  // Ready only in a quiescent state and never while reset is asserted
  assign key_in_ready = rst_n && ((state == ST_IDLE) || (state == ST_READY))
                        && !(LOCK_EN && key_lock);
  assign accept_c     = key_in_valid && key_in_ready;
  assign busy         = (state == ST_EXP1) || (state == ST_EXP2);

  // Operand/rcon mux for the shared g-function: previous round key by state
  always_comb begin
    g_in_c   = key0[7:0];
    w_hi_c   = key0[15:8];
    g_rcon_c = RCON1;
    if (state == ST_EXP2) begin
      g_in_c   = key1[7:0];
      w_hi_c   = key1[15:8];
      g_rcon_c = RCON2;
    end
  end

  saes_gfun u_gfun (
    .w    (g_in_c),
    .rcon (g_rcon_c),
    .gw_c (g_out_c)
  );

  assign new_hi_c = w_hi_c ^ g_out_c;
  assign new_lo_c = new_hi_c ^ g_in_c;

  // Controller FSM, key registers and completion counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      key0       <= '0;
      key1       <= '0;
      key2       <= '0;
      keys_valid <= 1'b0;
      exp_count  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (accept_c) begin
            key0       <= key_in;
            keys_valid <= 1'b0;
            state      <= ST_EXP1;
          end
        end
        ST_EXP1: begin
          key1  <= {new_hi_c, new_lo_c};
          state <= ST_EXP2;
        end
        ST_EXP2: begin
          key2       <= {new_hi_c, new_lo_c};
          keys_valid <= 1'b1;
          exp_count  <= exp_count + CNT_W'(1);
          state      <= ST_READY;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saes_key_sched_ctrl.sv
module tb_saes_key_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_in_valid;
  logic [15:0] key_in;
  logic        key_in_ready;
  logic        key_lock;
  logic        keys_valid;
  logic [15:0] key0, key1, key2;
  logic        busy;
  logic [7:0]  exp_count;

  logic        key_in_valid2;
  logic [15:0] key_in2;
  logic        key_in_ready2;
  logic        key_lock2;
  logic        keys_valid2;
  logic [15:0] key0_2, key1_2, key2_2;
  logic        busy2;
  logic [1:0]  exp_count2;

  int checks;
  int errors;

  saes_key_sched_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in_valid (key_in_valid),
    .key_in       (key_in),
    .key_in_ready (key_in_ready),
    .key_lock     (key_lock),
    .keys_valid   (keys_valid),
    .key0         (key0),
    .key1         (key1),
    .key2         (key2),
    .busy         (busy),
    .exp_count    (exp_count)
  );

  saes_key_sched_ctrl #(.CNT_W(2), .LOCK_EN(1'b0)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in_valid (key_in_valid2),
    .key_in       (key_in2),
    .key_in_ready (key_in_ready2),
    .key_lock     (key_lock2),
    .keys_valid   (keys_valid2),
    .key0         (key0_2),
    .key1         (key1_2),
    .key2         (key2_2),
    .busy         (busy2),
    .exp_count    (exp_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge; inputs are driven and outputs sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (key_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", key_in_ready); end
    checks++;
    if ({key0, key1, key2} !== 48'h0) begin errors++; $display("FAIL rst_keys got %h want 0", {key0, key1, key2}); end
    checks++;
    if (keys_valid !== 1'b0 || exp_count !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_status got v=%b c=%0d b=%b want 0/0/0", keys_valid, exp_count, busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (key_in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", key_in_ready); end
  endtask

  task automatic test_first_key();
    key_in_valid = 1'b1;
    key_in = 16'h4AF5;
    tick();
    key_in_valid = 1'b0;
    checks++;
    if (key0 !== 16'h4AF5 || busy !== 1'b1 || keys_valid !== 1'b0) begin
      errors++; $display("FAIL k1_accept got key0=%h b=%b v=%b want 4af5/1/0", key0, busy, keys_valid);
    end
    tick();
    checks++;
    if (key1 !== 16'hDD28 || keys_valid !== 1'b0) begin
      errors++; $display("FAIL k1_key1 got %h v=%b want dd28/0", key1, keys_valid);
    end
    tick();
    checks++;
    if (key2 !== 16'h87AF || keys_valid !== 1'b1 || exp_count !== 8'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL k1_done got key2=%h v=%b c=%0d b=%b want 87af/1/1/0", key2, keys_valid, exp_count, busy);
    end
  endtask

  task automatic test_lock();
    key_lock = 1'b1;
    key_in_valid = 1'b1;
    key_in = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (key_in_ready !== 1'b0) begin errors++; $display("FAIL lock_ready cyc %0d got %b want 0", i, key_in_ready); end
      tick();
    end
    checks++;
    if ({key0, key1, key2} !== 48'h4AF5_DD28_87AF || keys_valid !== 1'b1) begin
      errors++; $display("FAIL lock_hold got %h v=%b want 4af5dd2887af/1", {key0, key1, key2}, keys_valid);
    end
    key_lock = 1'b0;
    #1;
    checks++;
    if (key_in_ready !== 1'b1) begin errors++; $display("FAIL unlock_ready got %b want 1", key_in_ready); end
  endtask

  task automatic test_zero_key();
    int busy_cycles;
    int n;
    tick();
    key_in_valid = 1'b0;
    busy_cycles = busy ? 1 : 0;
    checks++;
    if (key0 !== 16'h0000 || keys_valid !== 1'b0) begin
      errors++; $display("FAIL zero_accept got key0=%h v=%b want 0000/0", key0, keys_valid);
    end
    n = 0;
    while (keys_valid !== 1'b1 && n < 10) begin
      tick();
      if (busy) busy_cycles++;
      n++;
    end
    checks++;
    if (n >= 10) begin errors++; $display("FAIL zero_timeout keys_valid never rose"); end
    checks++;
    if (busy_cycles != 2) begin errors++; $display("FAIL zero_busy got %0d cycles want 2", busy_cycles); end
    checks++;
    if (key1 !== 16'h1919 || key2 !== 16'h0D14 || exp_count !== 8'd2) begin
      errors++; $display("FAIL zero_keys got %h %h c=%0d want 1919 0d14 2", key1, key2, exp_count);
    end
  endtask

  task automatic test_valid_in_exp();
    key_in_valid = 1'b1;
    key_in = 16'h4AF5;
    tick();
    key_in = 16'h0000;
    #1;
    checks++;
    if (key_in_ready !== 1'b0) begin errors++; $display("FAIL exp1_ready got %b want 0", key_in_ready); end
    tick();
    checks++;
    if (key0 !== 16'h4AF5 || key1 !== 16'hDD28 || key_in_ready !== 1'b0) begin
      errors++; $display("FAIL exp2_hold got key0=%h key1=%h r=%b want 4af5/dd28/0", key0, key1, key_in_ready);
    end
    tick();
    checks++;
    if (key2 !== 16'h87AF || keys_valid !== 1'b1 || key_in_ready !== 1'b1 || exp_count !== 8'd3) begin
      errors++; $display("FAIL exp_ready got key2=%h v=%b r=%b c=%0d want 87af/1/1/3", key2, keys_valid, key_in_ready, exp_count);
    end
    tick();
    key_in_valid = 1'b0;
    checks++;
    if (key0 !== 16'h0000 || keys_valid !== 1'b0 || key1 !== 16'hDD28) begin
      errors++; $display("FAIL held_accept got key0=%h v=%b key1=%h want 0000/0/dd28", key0, keys_valid, key1);
    end
    tick();
    tick();
    checks++;
    if (key1 !== 16'h1919 || key2 !== 16'h0D14 || keys_valid !== 1'b1 || exp_count !== 8'd4) begin
      errors++; $display("FAIL held_done got %h %h v=%b c=%0d want 1919 0d14 1 4", key1, key2, keys_valid, exp_count);
    end
  endtask

  task automatic test_reset_mid_exp();
    key_in_valid = 1'b1;
    key_in = 16'h4AF5;
    tick();
    key_in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || key1 !== 16'hDD28) begin
      errors++; $display("FAIL midrst_pre got b=%b key1=%h want 1/dd28", busy, key1);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({key0, key1, key2} !== 48'h0 || keys_valid !== 1'b0 || exp_count !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst got %h v=%b c=%0d b=%b want 0/0/0/0", {key0, key1, key2}, keys_valid, exp_count, busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (key_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got ready=%b want 1", key_in_ready); end
  endtask

  task automatic test_wrap_nolock();
    logic [1:0]  exp_cnt [5];
    logic [15:0] keys    [5];
    logic [15:0] exp_k1  [5];
    logic [15:0] exp_k2  [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    keys    = '{16'h4AF5, 16'h0000, 16'h4AF5, 16'h0000, 16'h4AF5};
    exp_k1  = '{16'hDD28, 16'h1919, 16'hDD28, 16'h1919, 16'hDD28};
    exp_k2  = '{16'h87AF, 16'h0D14, 16'h87AF, 16'h0D14, 16'h87AF};
    key_lock2 = 1'b1;
    key_in_valid2 = 1'b1;
    for (int e = 0; e < 5; e++) begin
      key_in2 = keys[e];
      #1;
      checks++;
      if (key_in_ready2 !== 1'b1) begin errors++; $display("FAIL nolock_ready exp %0d got %b want 1", e, key_in_ready2); end
      tick();
      tick();
      tick();
      checks++;
      if (keys_valid2 !== 1'b1 || exp_count2 !== exp_cnt[e] || key1_2 !== exp_k1[e] || key2_2 !== exp_k2[e]) begin
        errors++;
        $display("FAIL wrap exp %0d got v=%b c=%0d k1=%h k2=%h want 1/%0d/%h/%h",
                 e, keys_valid2, exp_count2, key1_2, key2_2, exp_cnt[e], exp_k1[e], exp_k2[e]);
      end
    end
    key_in_valid2 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    key_in_valid = 1'b0;
    key_in = 16'h0;
    key_lock = 1'b0;
    key_in_valid2 = 1'b0;
    key_in2 = 16'h0;
    key_lock2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_key();
    test_lock();
    test_zero_key();
    test_valid_in_exp();
    test_reset_mid_exp();
    test_wrap_nolock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
